allgates_sweep_ctrl: RTL and testbench

Self-test sequencer for the two-input `allgates` gate unit. On request it drives the unit's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector. It samples the seven gate outputs, compares them against the expected truth table and reports pass/fail with an error summary. It sits beside the gate unit in place of the free-running testbench stimulus, so the sweep runs as in-system built-in self-test.

---
 rtl/allgates_sweep_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_allgates_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/allgates_sweep_ctrl.sv
// rtl/allgates_sweep_ctrl.sv - built-in self-test sequencer for the allgates gate unit
//
// Sweeps the gate unit inputs (a,b) through 00,10,01,11. Each vector is held for
// SETTLE cycles before gate_y is sampled and compared against the expected truth table.
// The mismatch count, the OR of all mismatch bits and a pass flag are reported for each run.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           run request (honoured only in IDLE)
//   cont            restart immediately at the end of a run
//   abort           abandon a run in progress
//   gate_y[6:0]     gate unit outputs {v,u,t,s,r,q,p}
//   gate_a, gate_b  gate unit inputs
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a complete run
//   pass            last completed run had no mismatching vectors
//   err_cnt[2:0]    vectors with at least one mismatching bit
//   fail_mask[6:0]  OR of mismatch bits over the run
//   runs[7:0]       completed-run counter, saturates at 255

module allgates_sweep_ctrl #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic       abort,
   input  logic [6:0] gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [6:0] fail_mask,
   output logic [7:0] runs
);

   // The settle counter runs 0..SETTLE within a vector. Sampling happens on the edge
   // that leaves count SETTLE-1. The extra count SETTLE is the hold cycle before the
   // next vector is driven, which gives a vector period of SETTLE+1.
   localparam logic [7:0] SAMPLE_CNT = 8'(SETTLE - 1);
   localparam logic [7:0] HOLD_CNT   = 8'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  vec_idx, vec_idx_nxt;
   logic [7:0]  settle_cnt, settle_cnt_nxt;
   logic        gate_a_nxt, gate_b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [2:0]  err_cnt_nxt;
   logic [6:0]  fail_mask_nxt;
   logic [7:0]  runs_nxt;

   logic [6:0]  expected;
   logic [6:0]  mismatch;
   logic [2:0]  err_inc;

   // The expected value follows the vector currently on the gate unit inputs.
   // Those inputs are the registered gate_a/gate_b outputs themselves.
   always_comb begin
      expected = {~gate_a, ~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a | gate_b),
                  ~(gate_a & gate_b), gate_a | gate_b, gate_a & gate_b};
      mismatch = gate_y ^ expected;
      err_inc  = err_cnt + {2'b00, |mismatch};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         vec_idx    <= 2'd0;
         settle_cnt <= 8'd0;
         gate_a     <= 1'b0;
         gate_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= 3'd0;
         fail_mask  <= 7'd0;
         runs       <= 8'd0;
      end else begin
         state      <= state_nxt;
         vec_idx    <= vec_idx_nxt;
         settle_cnt <= settle_cnt_nxt;
         gate_a     <= gate_a_nxt;
         gate_b     <= gate_b_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_cnt    <= err_cnt_nxt;
         fail_mask  <= fail_mask_nxt;
         runs       <= runs_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      vec_idx_nxt    = vec_idx;
      settle_cnt_nxt = settle_cnt;
      gate_a_nxt     = gate_a;
      gate_b_nxt     = gate_b;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      pass_nxt       = pass;
      err_cnt_nxt    = err_cnt;
      fail_mask_nxt  = fail_mask;
      runs_nxt       = runs;

      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt      = ST_RUN;
               busy_nxt       = 1'b1;
               vec_idx_nxt    = 2'd0;
               settle_cnt_nxt = 8'd0;
               gate_a_nxt     = 1'b0;
               gate_b_nxt     = 1'b0;
               pass_nxt       = 1'b0;
               err_cnt_nxt    = 3'd0;
               fail_mask_nxt  = 7'd0;
            end
         end

         ST_RUN: begin
            if (abort) begin
               // The sample that would have been taken on this edge is dropped.
               state_nxt  = ST_IDLE;
               busy_nxt   = 1'b0;
               gate_a_nxt = 1'b0;
               gate_b_nxt = 1'b0;
               pass_nxt   = 1'b0;
            end else if (settle_cnt == SAMPLE_CNT) begin
               err_cnt_nxt   = err_inc;
               fail_mask_nxt = fail_mask | mismatch;
               if (vec_idx == 2'd3) begin
                  state_nxt  = ST_DONE;
                  done_nxt   = 1'b1;
                  pass_nxt   = (err_inc == 3'd0);
                  runs_nxt   = (runs == 8'd255) ? runs : runs + 8'd1;
                  gate_a_nxt = 1'b0;
                  gate_b_nxt = 1'b0;
               end else begin
                  settle_cnt_nxt = HOLD_CNT;
               end
            end else if (settle_cnt == HOLD_CNT) begin
               // Vector order 00,10,01,11 makes a = idx[0] and b = idx[1].
               vec_idx_nxt    = vec_idx + 2'd1;
               settle_cnt_nxt = 8'd0;
               gate_a_nxt     = vec_idx_nxt[0];
               gate_b_nxt     = vec_idx_nxt[1];
            end else begin
               settle_cnt_nxt = settle_cnt + 8'd1;
            end
         end

         ST_DONE: begin
            if (cont && !abort) begin
               state_nxt      = ST_RUN;
               vec_idx_nxt    = 2'd0;
               settle_cnt_nxt = 8'd0;
               gate_a_nxt     = 1'b0;
               gate_b_nxt     = 1'b0;
               pass_nxt       = 1'b0;
               err_cnt_nxt    = 3'd0;
               fail_mask_nxt  = 7'd0;
            end else begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end
         end

         default: begin
            state_nxt  = ST_IDLE;
            busy_nxt   = 1'b0;
            gate_a_nxt = 1'b0;
            gate_b_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_allgates_sweep_ctrl.sv
// tb/tb_allgates_sweep_ctrl.sv - directed self-checking bench for allgates_sweep_ctrl

module tb_allgates_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, cont, abort;
   logic [6:0] gate_y;
   logic       gate_a, gate_b, busy, done, pass;
   logic [2:0] err_cnt;
   logic [6:0] fail_mask;
   logic [7:0] runs;

   logic [6:0] sa0, sa1;
   int         vec_cnt  = 0;
   int         miss_cnt = 0;
   logic [7:0] exp_runs = 8'd0;

   always #5 clk = ~clk;

   // Gate unit model with stuck-at fault injection.
   logic [6:0] good_y;
   assign good_y = {~gate_a, ~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a | gate_b),
                    ~(gate_a & gate_b), gate_a | gate_b, gate_a & gate_b};
   assign gate_y = (good_y & ~sa0) | sa1;

   allgates_sweep_ctrl #(.SETTLE(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
      .gate_y(gate_y), .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done),
      .pass(pass), .err_cnt(err_cnt), .fail_mask(fail_mask), .runs(runs)
   );

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; sa0 = '0; sa1 = '0;
      repeat (2) step();
      vec_cnt++;
      if ({gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs} !== 23'd0) begin
         miss_cnt++;
         $display("FAIL reset_values got=%h want=0",
                  {gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs});
      end
      rst_n = 1'b1;
      step();
   endtask

   // Runs one sweep from IDLE with the current fault setting and checks the result.
   task automatic test_good_unit();
      int done_seen = 0;
      sa0 = '0; sa1 = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if ({busy, gate_a, gate_b, pass} !== 4'b1000) begin
         miss_cnt++;
         $display("FAIL good_e0 got busy,a,b,pass=%b want=1000", {busy, gate_a, gate_b, pass});
      end
      for (int n = 1; n <= 24; n++) begin
         step();
         if (done) done_seen++;
         if (n == 5 || n == 10 || n == 15) begin
            vec_cnt++;
            if ({gate_a, gate_b} !== ((n == 5) ? 2'b10 : (n == 10) ? 2'b01 : 2'b11)) begin
               miss_cnt++;
               $display("FAIL good_vec_edge%0d got ab=%b%b", n, gate_a, gate_b);
            end
         end
         if (n == 19) begin
            exp_runs++;
            vec_cnt++;
            if ({done, pass, err_cnt, fail_mask, runs} !== {1'b1, 1'b1, 3'd0, 7'd0, exp_runs}) begin
               miss_cnt++;
               $display("FAIL good_done got done=%b pass=%b err=%0d mask=%b runs=%0d want 1 1 0 0 %0d",
                        done, pass, err_cnt, fail_mask, runs, exp_runs);
            end
         end
         if (n == 20) begin
            vec_cnt++;
            if ({busy, done} !== 2'b00) begin
               miss_cnt++;
               $display("FAIL good_idle got busy=%b done=%b want 0 0", busy, done);
            end
         end
      end
      vec_cnt++;
      if (done_seen != 1) begin
         miss_cnt++;
         $display("FAIL good_done_width got %0d cycles want 1", done_seen);
      end
   endtask

   task automatic test_faults();
      logic [6:0] want_mask;
      logic [2:0] want_err;
      for (int f = 0; f < 2; f++) begin
         sa0 = (f == 0) ? 7'b0000001 : 7'b0000000;
         sa1 = (f == 0) ? 7'b0000000 : 7'b1000000;
         want_err  = (f == 0) ? 3'd1 : 3'd2;
         want_mask = (f == 0) ? 7'b0000001 : 7'b1000000;
         start = 1'b1;
         step();
         start = 1'b0;
         repeat (19) step();
         exp_runs++;
         vec_cnt++;
         if ({done, pass, err_cnt, fail_mask, runs} !== {1'b1, 1'b0, want_err, want_mask, exp_runs}) begin
            miss_cnt++;
            $display("FAIL fault%0d got done=%b pass=%b err=%0d mask=%b runs=%0d want 1 0 %0d %b %0d",
                     f, done, pass, err_cnt, fail_mask, runs, want_err, want_mask, exp_runs);
         end
         step();
      end
      sa0 = '0; sa1 = '0;
   endtask

   task automatic test_back_to_back();
      int done_seen = 0;
      cont = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         step();
         if (done) done_seen++;
         if (n == 19 || n == 39 || n == 59) begin
            exp_runs++;
            vec_cnt++;
            if ({done, pass, runs} !== {2'b11, exp_runs}) begin
               miss_cnt++;
               $display("FAIL cont_done_edge%0d got done=%b pass=%b runs=%0d want 1 1 %0d",
                        n, done, pass, runs, exp_runs);
            end
         end
         if (n == 20 || n == 40) begin
            vec_cnt++;
            if ({busy, gate_a, gate_b, pass} !== 4'b1000) begin
               miss_cnt++;
               $display("FAIL cont_restart_edge%0d got busy,a,b,pass=%b want 1000",
                        n, {busy, gate_a, gate_b, pass});
            end
         end
         if (n == 25 || n == 45) begin
            vec_cnt++;
            if ({gate_a, gate_b} !== 2'b10) begin
               miss_cnt++;
               $display("FAIL cont_vec1_edge%0d got ab=%b%b want 10", n, gate_a, gate_b);
            end
         end
         if (n == 58) cont = 1'b0;
      end
      vec_cnt++;
      if ({busy, done_seen[3:0], runs} !== {1'b0, 4'd3, exp_runs}) begin
         miss_cnt++;
         $display("FAIL cont_end got busy=%b dones=%0d runs=%0d want 0 3 %0d",
                  busy, done_seen, runs, exp_runs);
      end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      sa0 = 7'b0000100;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (6) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      vec_cnt++;
      if ({busy, gate_a, gate_b, done, pass, err_cnt, fail_mask, runs} !==
          {5'b00000, 3'd1, 7'b0000100, exp_runs}) begin
         miss_cnt++;
         $display("FAIL abort_state got busy=%b ab=%b%b done=%b pass=%b err=%0d mask=%b runs=%0d",
                  busy, gate_a, gate_b, done, pass, err_cnt, fail_mask, runs);
      end
      for (int n = 0; n < 16; n++) begin
         step();
         if (done || busy) done_seen++;
      end
      vec_cnt++;
      if (done_seen != 0) begin
         miss_cnt++;
         $display("FAIL abort_quiet got %0d busy/done cycles want 0", done_seen);
      end
      sa0 = '0;
   endtask

   task automatic test_start_while_busy();
      int done_seen = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         start = (n == 3 || n == 12);
         step();
         if (done) done_seen++;
      end
      start = 1'b0;
      exp_runs++;
      vec_cnt++;
      if ({busy, pass, done_seen[3:0], runs} !== {2'b01, 4'd1, exp_runs}) begin
         miss_cnt++;
         $display("FAIL start_busy got busy=%b pass=%b dones=%0d runs=%0d want 0 1 1 %0d",
                  busy, pass, done_seen, runs, exp_runs);
      end
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      vec_cnt++;
      if ({busy, gate_a, gate_b} !== 3'b000) begin
         miss_cnt++;
         $display("FAIL start_abort_idle got busy,a,b=%b want 000", {busy, gate_a, gate_b});
      end
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (7) step();
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs} !== 23'd0) begin
         miss_cnt++;
         $display("FAIL async_reset got=%h want=0",
                  {gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs});
      end
      #3;
      rst_n = 1'b1;
      repeat (6) step();
      vec_cnt++;
      if ({gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs} !== 23'd0) begin
         miss_cnt++;
         $display("FAIL after_reset got=%h want=0",
                  {gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, runs});
      end
   endtask

   initial begin
      test_reset();
      test_good_unit();
      test_faults();
      test_back_to_back();
      test_abort();
      test_start_while_busy();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
